mem_port_arbiter: RTL

Shares the single-port unified instruction/data memory of the multicycle CPU between two requesters: the instruction-fetch path (IR load) and the load/store data path. Each requester runs a level req/done handshake. The arbiter owns the memory control strobes and the address/data muxing, so the control FSM no longer drives MEM_RD/MEM_WD/SEL_DIR directly. It inserts wait states for a memory with fixed read latency.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter_rr_pick2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_t      : FSM state encoding (IDLE / ACCESS / DONE)
//   REQ_IF/REQ_D : requester IDs (instruction fetch / data path)
//   MEM_LAT_MAX  : largest read latency the 4-bit latency counter can reach
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam int MEM_LAT_MAX = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory bus for the memory port arbiter.
//   fetch side : if_req, if_addr -> if_rdata, if_done
//   data side  : d_req, d_we, d_addr, d_wdata -> d_rdata, d_done
//   memory side: mem_addr, mem_wdata, mem_re, mem_we <- mem_rdata
//   status     : busy
// Modport slave is the arbiter's view; master is the requester/memory view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_done, d_rdata, d_done,
           mem_addr, mem_wdata, mem_re, mem_we, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_done, d_rdata, d_done,
           mem_addr, mem_wdata, mem_re, mem_we, busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input round-robin chooser (combinational).
//   req[1:0]    : request levels, indexed by requester ID
//   last_grant  : ID served most recently
//   grant_valid : any request present
//   grant_id    : chosen requester; on a tie, the one not served last
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_IF;
    if (req[REQ_D] && (!req[REQ_IF] || last_grant == REQ_IF)) begin
      grant_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// the load/store path, owning the memory strobes and address/data muxing.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : requester handshakes, memory bus and busy (slave modport)
//
// state  | meaning
// IDLE   | sample requests, register grant and latch request attributes
// ACCESS | memory strobes active (MEM_LAT read cycles or one write cycle)
// DONE   | done pulse to the granted requester, captured data on its rdata
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  // Out-of-range latencies are clamped to what the 4-bit counter supports.
  localparam logic [3:0] LAT_LAST = (MEM_LAT < 1)           ? 4'd1 :
                                    (MEM_LAT > MEM_LAT_MAX) ? 4'(MEM_LAT_MAX) :
                                                              4'(MEM_LAT);

  state_t        state, state_nxt;
  logic          grant_valid, grant_id;
  logic          gnt_q, last_grant, we_q;
  logic          access_last;
  logic [3:0]    lat_cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;

  rr_pick2 u_pick (
    .req         ({bus.d_req, bus.if_req}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // A store always finishes after its single write cycle.
  assign access_last = we_q || (lat_cnt == LAT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_done   = 1'b0;
    bus.d_done    = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rdata   = '0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        bus.mem_addr = addr_q;
        bus.mem_re   = ~we_q;
        bus.mem_we   = we_q;
        if (we_q) bus.mem_wdata = wdata_q;
        if (access_last) state_nxt = DONE;
      end
      DONE: begin
        if (gnt_q == REQ_IF) begin
          bus.if_done  = 1'b1;
          bus.if_rdata = rdata_q;
        end else begin
          bus.d_done  = 1'b1;
          bus.d_rdata = rdata_q;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q      <= REQ_IF;
      last_grant <= REQ_D;
      we_q       <= 1'b0;
      lat_cnt    <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            gnt_q   <= grant_id;
            we_q    <= (grant_id == REQ_D) && bus.d_we;
            addr_q  <= (grant_id == REQ_D) ? bus.d_addr : bus.if_addr;
            wdata_q <= bus.d_wdata;
            lat_cnt <= 4'd1;
          end
        end
        ACCESS: begin
          if (access_last) begin
            rdata_q <= we_q ? '0 : bus.mem_rdata;
            lat_cnt <= 4'd0;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        DONE: begin
          last_grant <= gnt_q;
        end
        default: ;
      endcase
    end
  end

endmodule
